// File: rtl/toll_engine_multiclass.sv
// toll_engine_multiclass: multi-account, multi-class toll charging engine.
// Keeps a balance table for NUM_ACCOUNTS vehicles, charges a fee chosen by
// vehicle class, holds the gate open for GATE_HOLD cycles after a pass and
// accepts saturating balance top-ups.
//
// Handshake: a top-up transfers on any rising edge where topup_valid and
// topup_ready are both high; topup_ready never depends on topup_valid.
//
// Optional build macro TOLL_LOW_BAL_WARN_EN adds the registered low_bal_warn
// output, raised with transaction_done when a pass leaves the balance below
// LOW_BAL_THRESH.
module toll_engine_multiclass #(
    parameter int ID_W           = 4,
    parameter int NUM_ACCOUNTS   = 16,
    parameter int BAL_W          = 10,
    parameter int INIT_BAL       = 0,
    parameter int FEE_C0         = 50,
    parameter int FEE_C1         = 80,
    parameter int FEE_C2         = 120,
    parameter int FEE_C3         = 200,
    parameter int GATE_HOLD      = 4,
    parameter int LOW_BAL_THRESH = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_transaction,
    input  logic [ID_W-1:0]  vehicle_id_in,
    input  logic [1:0]       vehicle_class_in,
    input  logic             topup_valid,
    input  logic [ID_W-1:0]  topup_id,
    input  logic [BAL_W-1:0] topup_amount,
    output logic             topup_ready,
    output logic             busy,
    output logic             gate_open,
    output logic [1:0]       display_signal,
    output logic [1:0]       transaction_status,
    output logic             transaction_done,
`ifdef TOLL_LOW_BAL_WARN_EN
    output logic             low_bal_warn,
`endif
    output logic [BAL_W-1:0] balance_out
);

    localparam int CNT_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
    localparam logic [ID_W:0] NUM_ACC = (ID_W+1)'(NUM_ACCOUNTS);

    typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, GATE} state_t;

    state_t           state;
    logic [BAL_W-1:0] bal_mem [NUM_ACCOUNTS];
    logic [ID_W-1:0]  lat_id;
    logic [1:0]       lat_class;
    logic [BAL_W-1:0] bal_q;
    logic [BAL_W-1:0] fee_q;
    logic             inv_q;
    logic [CNT_W-1:0] hold_cnt;

    logic             topup_fire;
    logic             topup_hit;
    logic [BAL_W:0]   topup_sum;
    logic [BAL_W-1:0] topup_new;
    logic             lat_valid;
    logic [BAL_W-1:0] fee_sel;
    logic [BAL_W-1:0] charge_new;
    logic             charge_pass;

    // Top-up acceptance, saturating add, fee selection and charge arithmetic.
    always_comb begin
        topup_ready = ((state == IDLE) && !start_transaction) || (state == GATE);
        topup_fire  = topup_valid && topup_ready;
        topup_hit   = ({1'b0, topup_id} < NUM_ACC);
        topup_sum   = '0;
        if (topup_hit)
            topup_sum = {1'b0, bal_mem[topup_id]} + {1'b0, topup_amount};
        topup_new   = topup_sum[BAL_W] ? {BAL_W{1'b1}} : topup_sum[BAL_W-1:0];
        lat_valid   = ({1'b0, lat_id} < NUM_ACC);
        case (lat_class)
            2'd0:    fee_sel = BAL_W'(FEE_C0);
            2'd1:    fee_sel = BAL_W'(FEE_C1);
            2'd2:    fee_sel = BAL_W'(FEE_C2);
            default: fee_sel = BAL_W'(FEE_C3);
        endcase
        charge_pass = !inv_q && (bal_q >= fee_q);
        charge_new  = bal_q - fee_q;
        busy        = (state != IDLE);
    end

    // Transaction FSM, registered outputs and balance table updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            lat_id             <= '0;
            lat_class          <= '0;
            bal_q              <= '0;
            fee_q              <= '0;
            inv_q              <= 1'b0;
            hold_cnt           <= '0;
            gate_open          <= 1'b0;
            display_signal     <= 2'b00;
            transaction_status <= 2'b00;
            transaction_done   <= 1'b0;
            balance_out        <= '0;
`ifdef TOLL_LOW_BAL_WARN_EN
            low_bal_warn       <= 1'b0;
`endif
            for (int i = 0; i < NUM_ACCOUNTS; i++)
                bal_mem[i] <= BAL_W'(INIT_BAL);
        end else begin
            transaction_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_transaction) begin
                        lat_id             <= vehicle_id_in;
                        lat_class          <= vehicle_class_in;
                        display_signal     <= 2'b00;
                        transaction_status <= 2'b00;
`ifdef TOLL_LOW_BAL_WARN_EN
                        low_bal_warn       <= 1'b0;
`endif
                        state              <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    bal_q <= lat_valid ? bal_mem[lat_id] : '0;
                    fee_q <= fee_sel;
                    inv_q <= !lat_valid;
                    state <= CHECK;
                end
                CHECK: begin
                    transaction_done <= 1'b1;
                    if (inv_q) begin
                        transaction_status <= 2'b11;
                        display_signal     <= 2'b11;
                        balance_out        <= '0;
                        state              <= IDLE;
                    end else if (charge_pass) begin
                        bal_mem[lat_id]    <= charge_new;
                        transaction_status <= 2'b01;
                        display_signal     <= 2'b01;
                        balance_out        <= charge_new;
                        gate_open          <= 1'b1;
                        hold_cnt           <= CNT_W'(GATE_HOLD - 1);
`ifdef TOLL_LOW_BAL_WARN_EN
                        low_bal_warn       <= (int'(charge_new) < LOW_BAL_THRESH);
`endif
                        state              <= GATE;
                    end else begin
                        transaction_status <= 2'b10;
                        display_signal     <= 2'b10;
                        balance_out        <= bal_q;
                        state              <= IDLE;
                    end
                end
                GATE: begin
                    if (hold_cnt == '0) begin
                        gate_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Top-ups never coincide with the CHECK write-back (ready is low in
            // CHECK), so a GATE top-up always lands on the post-deduction value.
            if (topup_fire && topup_hit)
                bal_mem[topup_id] <= topup_new;
        end
    end

endmodule

// File: tb/tb_toll_engine_multiclass.sv
// Directed bench for toll_engine_multiclass with hand-computed expectations.
module tb_toll_engine_multiclass;

  localparam int ID_W  = 4;
  localparam int BAL_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_transaction;
  logic [ID_W-1:0]  vehicle_id_in;
  logic [1:0]       vehicle_class_in;
  logic             topup_valid;
  logic [ID_W-1:0]  topup_id;
  logic [BAL_W-1:0] topup_amount;
  logic             topup_ready;
  logic             busy;
  logic             gate_open;
  logic [1:0]       display_signal;
  logic [1:0]       transaction_status;
  logic             transaction_done;
  logic [BAL_W-1:0] balance_out;
`ifdef TOLL_LOW_BAL_WARN_EN
  logic             low_bal_warn;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  toll_engine_multiclass #(.NUM_ACCOUNTS(12)) dut (
    .clk                (clk),
    .reset              (reset),
    .start_transaction  (start_transaction),
    .vehicle_id_in      (vehicle_id_in),
    .vehicle_class_in   (vehicle_class_in),
    .topup_valid        (topup_valid),
    .topup_id           (topup_id),
    .topup_amount       (topup_amount),
    .topup_ready        (topup_ready),
    .busy               (busy),
    .gate_open          (gate_open),
    .display_signal     (display_signal),
    .transaction_status (transaction_status),
    .transaction_done   (transaction_done),
`ifdef TOLL_LOW_BAL_WARN_EN
    .low_bal_warn       (low_bal_warn),
`endif
    .balance_out        (balance_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_gate"}, gate_open, 0);
    check_eq({tag, "_done"}, transaction_done, 0);
    check_eq({tag, "_status"}, transaction_status, 0);
    check_eq({tag, "_display"}, display_signal, 0);
    check_eq({tag, "_bal"}, balance_out, 0);
    check_eq({tag, "_tready"}, topup_ready, 1);
  endtask

  // driver: one top-up transfer from IDLE
  task automatic do_topup(input int id, input int amt);
    topup_valid  = 1'b1;
    topup_id     = ID_W'(id);
    topup_amount = BAL_W'(amt);
    check_eq($sformatf("topup_ready_id%0d", id), topup_ready, 1);
    @(posedge clk); #1;
    topup_valid = 1'b0;
  endtask

  // driver + checker: one charge; optional same-cycle top-up, start poke and
  // top-up during GATE
  task automatic do_charge(input int id, input int cls, input int exp_st, input int exp_bal,
                           input bit tu_same, input bit poke, input int gate_tu);
    string t;
    int gate_cnt;
    int extra_done;
    t = $sformatf("id%0d_c%0d", id, cls);
    vehicle_id_in     = ID_W'(id);
    vehicle_class_in  = 2'(cls);
    start_transaction = 1'b1;
    if (tu_same) begin
      topup_valid  = 1'b1;
      topup_id     = ID_W'(id);
      topup_amount = BAL_W'(100);
      #1;
      check_eq({t, "_tready_vs_start"}, topup_ready, 0);
    end
    @(posedge clk); #1;
    start_transaction = 1'b0;
    topup_valid       = 1'b0;
    vehicle_id_in     = '1;
    vehicle_class_in  = 2'd3;
    check_eq({t, "_busy_lookup"}, busy, 1);
    check_eq({t, "_status_clr"}, transaction_status, 0);
    check_eq({t, "_display_clr"}, display_signal, 0);
    @(posedge clk); #1;
    check_eq({t, "_done_early"}, transaction_done, 0);
    @(posedge clk); #1;
    check_eq({t, "_done"}, transaction_done, 1);
    check_eq({t, "_status"}, transaction_status, exp_st);
    check_eq({t, "_display"}, display_signal, exp_st);
    check_eq({t, "_bal"}, balance_out, exp_bal);
    check_eq({t, "_gate"}, gate_open, (exp_st == 1) ? 1 : 0);
    if (exp_st == 1) begin
      gate_cnt   = 1;
      extra_done = 0;
      for (int i = 0; i < 20; i++) begin
        if (i == 0) begin
          if (poke) begin
            start_transaction = 1'b1;
            vehicle_id_in     = ID_W'(id);
            vehicle_class_in  = 2'd0;
          end
          if (gate_tu > 0) begin
            topup_valid  = 1'b1;
            topup_id     = ID_W'(id);
            topup_amount = BAL_W'(gate_tu);
          end
        end
        @(posedge clk); #1;
        start_transaction = 1'b0;
        topup_valid       = 1'b0;
        if (transaction_done) extra_done++;
        if (!gate_open) break;
        gate_cnt++;
      end
      check_eq({t, "_gate_cycles"}, gate_cnt, 4);
      check_eq({t, "_extra_done"}, extra_done, 0);
    end else begin
      @(posedge clk); #1;
      check_eq({t, "_gate_after"}, gate_open, 0);
      check_eq({t, "_done_pulse"}, transaction_done, 0);
    end
    check_eq({t, "_busy_end"}, busy, 0);
  endtask

  initial begin
    reset             = 1'b1;
    start_transaction = 1'b0;
    vehicle_id_in     = '0;
    vehicle_class_in  = '0;
    topup_valid       = 1'b0;
    topup_id          = '0;
    topup_amount      = '0;
    repeat (10) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // basic pass: 200 - 50
    do_topup(2, 200);
    do_charge(2, 0, 1, 150, 0, 0, 0);

    // insufficient, then refill and pass at exact balance
    do_topup(1, 40);
    do_charge(1, 0, 2, 40, 0, 0, 0);
    do_topup(1, 10);
    do_charge(1, 0, 1, 0, 0, 0, 0);

    // exact balance, then deduction persists
    do_topup(4, 50);
    do_charge(4, 0, 1, 0, 0, 0, 0);
    do_charge(4, 0, 2, 0, 0, 0, 0);

    // class-dependent fees on id2 (150)
    do_charge(2, 2, 1, 30, 0, 0, 0);
    do_charge(2, 3, 2, 30, 0, 0, 0);

    // saturation: 1000 + 1000 -> 1023, minus 50
    do_topup(3, 1000);
    do_topup(3, 1000);
    do_charge(3, 0, 1, 973, 0, 0, 0);

    // top-up in the same IDLE cycle as start is not taken
    do_charge(5, 0, 2, 0, 1, 0, 0);

    // invalid ID with NUM_ACCOUNTS=12
    do_charge(13, 0, 3, 0, 0, 0, 0);

    // start during GATE ignored; top-up during GATE lands after deduction
    do_topup(6, 100);
    do_charge(6, 0, 1, 50, 0, 1, 25);
    do_charge(6, 0, 1, 25, 0, 0, 0);

    // reset asserted while in CHECK
    do_topup(7, 100);
    vehicle_id_in     = ID_W'(7);
    vehicle_class_in  = 2'd0;
    start_transaction = 1'b1;
    @(posedge clk); #1;
    start_transaction = 1'b0;
    @(posedge clk); #1;
    check_eq("in_check_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_in_check");
    reset = 1'b0;
    @(posedge clk); #1;
    do_charge(7, 0, 2, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/toll_engine_multiclass.md
Name: toll_engine_multiclass

Overview:
- Parametrised successor of the single-fee toll controller.
- Holds an on-chip balance table for NUM_ACCOUNTS vehicles and charges a class-dependent fee (four vehicle classes).
- Accepts balance top-ups through a valid/ready port, holds the gate open for a programmable number of cycles, and rejects invalid IDs explicitly.
- Sits between the tag-reader front end and the gate/display drivers of the toll system top.

Parameters:
- ID_W, 4: vehicle ID width.
- NUM_ACCOUNTS, 16: valid IDs are 0..NUM_ACCOUNTS-1; must be <= 2^ID_W.
- BAL_W, 10: balance width in units; balances saturate at 2^BAL_W-1.
- INIT_BAL, 0: value loaded into every balance on reset.
- FEE_C0 / FEE_C1 / FEE_C2 / FEE_C3, 50 / 80 / 120 / 200: fee per vehicle class.
- GATE_HOLD, 4: number of cycles gate_open stays high after a pass; must be >= 1.
- LOW_BAL_THRESH, 100: low-balance warning threshold (used only by the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start_transaction  in  1  request a charge; sampled only in IDLE
- vehicle_id_in  in  ID_W  ID to charge
- vehicle_class_in  in  2  selects FEE_C0..FEE_C3
- topup_valid  in  1  top-up request
- topup_id  in  ID_W  account to credit
- topup_amount  in  BAL_W  credit amount
- topup_ready  out  1  top-up accepted when valid && ready
- busy  out  1  high in any state except IDLE
- gate_open  out  1  gate drive
- display_signal  out  2  00 off, 01 green, 10 red, 11 amber (invalid ID)
- transaction_status  out  2  00 none, 01 pass, 10 insufficient, 11 invalid ID
- transaction_done  out  1  one-cycle pulse marking a result
- balance_out  out  BAL_W  post-transaction balance of the charged ID (0 if invalid)

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; every balance loads INIT_BAL.
  - All outputs 0, except topup_ready, which follows the IDLE rule below.
  - Reset mid-operation abandons the transaction with no deduction; the reset value wins over any same-cycle update.
- FSM states: IDLE, LOOKUP, CHECK, GATE.
- IDLE:
  - start_transaction=1 at an edge latches the ID and class, then goes to LOOKUP.
  - display_signal and transaction_status keep their last result until that edge, then both clear to 00.
- LOOKUP (1 cycle):
  - Registers the balance of the latched ID and the selected fee.
  - Flags invalid if ID >= NUM_ACCOUNTS.
  - Goes to CHECK.
- CHECK (1 cycle). At its closing edge the block registers the result and pulses transaction_done for one cycle:
  - Invalid ID: status 11, display 11, balance_out 0; go to IDLE.
  - Balance >= fee (equal counts as pass): write balance-fee back to the table; status 01, display 01, balance_out = new balance; gate_open=1; load the hold counter with GATE_HOLD-1; go to GATE.
  - Balance < fee: no write; status 10, display 10, balance_out = old balance; go to IDLE.
- Latency: done and gate_open are first high two edges after the edge that samples start.
- GATE:
  - gate_open stays high for exactly GATE_HOLD cycles in total.
  - When the counter reaches 0: gate_open=0, go to IDLE.
- start_transaction outside IDLE is ignored; there is no queueing.
- Top-up:
  - topup_ready = (state==IDLE && !start_transaction) || state==GATE. A transaction has priority in IDLE.
  - On acceptance, at that edge: balance = min(balance+topup_amount, 2^BAL_W-1), with the add computed at BAL_W+1 bits.
  - A top-up to an invalid ID is accepted and discarded.
  - A top-up in GATE to the just-charged ID applies after the deduction, so no write is lost.
- vehicle_class_in and vehicle_id_in are don't-care except at the start edge.

Optional Feature:
- Macro TOLL_LOW_BAL_WARN_EN.
- When defined: adds output low_bal_warn (1 bit), registered. It sets with transaction_done on a pass when the new balance < LOW_BAL_THRESH, and clears on the next accepted start or on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults (INIT_BAL=0), reset 10 cycles; top-up id2 +200; start id2 class0 -> done 2 edges after start, status 01, display 01, balance_out 150, gate_open high exactly 4 cycles, busy low afterwards.
- Top-up id1 +40; start id1 class0 -> status 10, display 10, gate_open never high, balance_out 40; a re-top-up of +10 then a retry passes with balance_out 0.
- Top-up id4 +50; class0 pass -> balance_out 0; immediate retry on id4 -> status 10 (exact-balance boundary and deduction persistence).
- id2 at 150, class2 -> pass, balance_out 30; class3 -> status 10, balance unchanged at 30.
- Top-up id3 +1000 twice -> a charge with class0 reports balance_out 973 (saturated at 1023 before the charge). Top-up issued in the same IDLE cycle as start -> topup_ready low, top-up not taken.
- NUM_ACCOUNTS=12: start id13 -> status 11, display 11, no gate. Start pulsed during GATE -> ignored. Reset asserted in CHECK -> all outputs 0 and the charged balance reverts to INIT_BAL.
